reorder_logic_sequencer: RTL

- Control stage directly upstream of the re-order selector.
- Holds the next expected queue index, drives the selector's valid/next request, and consumes the per-queue pull-acknowledge the selector returns.
- On each acknowledged pull it captures the popped word into a one-entry output register with a valid/ready handshake, advances the expected index with wrap-around, and flags protocol errors and stalls.

---
 rtl/reorder_logic_sequencer.sv | 93 +++++++++
 1 files changed

// File: rtl/reorder_logic_sequencer.sv
// Sequencer in front of the re-order selector: requests queues in strict index order,
// registers each pulled word behind a valid/ready handshake, and flags protocol errors and stalls.
module reorder_logic_sequencer #(
    parameter int NUM_QUEUES  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int STALL_LIMIT = 255,
    localparam int SEL_WIDTH  = $clog2(NUM_QUEUES)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic                             clear_i,
    input  logic [NUM_QUEUES-1:0]            status_i,
    input  logic [NUM_QUEUES-1:0]            ack_i,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] queue_data_i,
    output logic                             valid_o,
    output logic [SEL_WIDTH-1:0]             next_o,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [DATA_WIDTH-1:0]            out_data_o,
    output logic [SEL_WIDTH-1:0]             out_tag_o,
    output logic                             error_o,
    output logic                             timeout_o
);

    localparam int CNT_WIDTH = $clog2(STALL_LIMIT + 1);

    logic [NUM_QUEUES-1:0][DATA_WIDTH-1:0] qword;
    logic [NUM_QUEUES-1:0]                 exp_onehot;
    logic [SEL_WIDTH-1:0]                  next_wrap;
    logic [CNT_WIDTH-1:0]                  stall_cnt;
    logic                                  ack_bad;
    logic                                  pull;
    logic                                  xfer;
    logic                                  starve;
    logic                                  timeout_set;

    assign qword      = queue_data_i;
    assign exp_onehot = {{(NUM_QUEUES-1){1'b0}}, 1'b1} << next_o;

    // Request depends only on registered state, enable and downstream ready.
    assign valid_o = enable_i & ~rst_i & (~out_valid_o | out_ready_i);

    // Any ack off the expected index, or any ack without a request, is a protocol error.
    assign ack_bad = (|(ack_i & ~exp_onehot)) | ((|ack_i) & ~valid_o);
    assign pull    = valid_o & (|(ack_i & exp_onehot)) & ~ack_bad;
    assign xfer    = out_valid_o & out_ready_i;
    assign starve  = valid_o & ~(|(status_i & exp_onehot));

    // Timeout fires on the step that brings the counter up to the limit.
    assign timeout_set = ~ack_bad & ~pull & starve &
                         (stall_cnt == CNT_WIDTH'(STALL_LIMIT - 1));

    assign next_wrap = (next_o == SEL_WIDTH'(NUM_QUEUES - 1)) ? '0 : next_o + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            next_o      <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_tag_o   <= '0;
            error_o     <= 1'b0;
            timeout_o   <= 1'b0;
            stall_cnt   <= '0;
        end else if (ack_bad) begin
            // A bad ack cycle leaves everything frozen except the error flag.
            error_o <= 1'b1;
        end else begin
            if (clear_i)
                error_o <= 1'b0;

            if (timeout_set)
                timeout_o <= 1'b1;
            else if (clear_i)
                timeout_o <= 1'b0;

            if (pull || !enable_i || clear_i)
                stall_cnt <= '0;
            else if (starve && stall_cnt != CNT_WIDTH'(STALL_LIMIT))
                stall_cnt <= stall_cnt + 1'b1;

            if (pull) begin
                out_data_o  <= qword[next_o];
                out_tag_o   <= next_o;
                out_valid_o <= 1'b1;
                next_o      <= next_wrap;
            end else if (xfer) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule
